hamming_tx_serializer: RTL and testbench
========================================

# hamming_tx_serializer

Transmit-side stage of the Hamming(15,11) link. It accepts an 11-bit data word over a valid/ready handshake and encodes it into a 15-bit codeword. It then shifts the codeword out LSB-first on a one-bit serial line with a programmable bit period. The codeword bit layout is exactly the one the downstream corrector decodes: parity at indices 0/1/3/7, data elsewhere.

## Interface
Parameters:
- CLKS_PER_BIT, default 1: clock cycles each serial bit is held. Legal range 1..255.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  reset; synchronous and active-low.
- din  input  11  data word to encode.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept a word.
- codeword  output  15  registered encoded word. Updated on accept, held until the next accept.
- serial_out  output  1  serial bitstream, LSB (index 0) first. Driven 0 when not shifting.
- serial_valid  output  1  high while serial_out carries a codeword bit.
- frame_start  output  1  high during every cycle of bit 0's period.
- done  output  1  one-cycle pulse after the last bit.

## Operation
Data mapping (din bit → codeword index):
- din[0]→2, din[1]→4, din[2]→5, din[3]→6.
- din[4..10]→8..14.

Parity bits (XOR over codeword indices):
- idx0 = 2^4^6^8^10^12^14
- idx1 = 2^5^6^9^10^13^14
- idx3 = 4^5^6^11^12^13^14
- idx7 = 8^9^10^11^12^13^14

FSM states:
- IDLE: din_ready=1. A transfer (din_valid && din_ready) latches the encoded word into codeword and a shift register, clears bit_idx and the bit-period counter, and goes to SHIFT.
- SHIFT: din_ready=0, serial_valid=1, serial_out=shift_reg[bit_idx].
  - The bit-period counter runs 0..CLKS_PER_BIT-1.
  - When it wraps, bit_idx increments.
  - When it wraps with bit_idx==14, go to DONE.
- DONE: exactly one cycle. done=1, serial_valid=0, serial_out=0, din_ready=0. Then go to IDLE.

Handshake and boundary rules:
- din_valid while din_ready=0 is ignored; no buffering. din may change freely when no transfer occurs.
- din_valid held high continuously: a new word is accepted on the first IDLE cycle after DONE.
- Reset, including mid-frame: next state is IDLE and the partial frame is discarded, with no done pulse.
- Reset values: din_ready=1, codeword=0, serial_out=0, serial_valid=0, frame_start=0, done=0, bit_idx=0, counter=0.
- bit_idx is 4 bits and never exceeds 14. The counter is 8 bits.
- All outputs are registered or decoded from state only; there is no combinational path from din/din_valid to any output.

## Timing
- Accept at edge k: codeword is valid from cycle k+1.
- Bit n occupies cycles k+1+n·CPB through k+(n+1)·CPB.
- frame_start is high for cycles k+1..k+CPB.
- done is high in cycle k+15·CPB+1.
- din_ready is high again in cycle k+15·CPB+2, which is the earliest next accept edge.
- Minimum word spacing is 15·CPB+2 cycles. With CPB=1 that is 17 cycles.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release. All outputs are 0 except din_ready=1. Asserting din_valid in the reset cycle is ignored.
- Encoding (CPB=1): din 0x000→codeword 0x0000; 0x7FF→0x7FFF; 0x001→0x0007; 0x010→0x0181. The serial stream matches codeword LSB-first, serial_valid is high for exactly 15 cycles, and done follows one cycle later.
- Timing with CPB=3: 0x010 gives serial_out=1 in cycles 1-3, 22-24 and 25-27 after accept, and 0 elsewhere. frame_start is high in cycles 1-3 only. done is high in cycle 46.
- Back-to-back: din_valid held high with 0x001 then 0x7FF. The second accept happens exactly 17 cycles after the first (CPB=1). din changes while busy do not alter the stream or codeword.
- Mid-frame reset: pull rst_n low during bit 7. The next cycle is IDLE, there is no done pulse, and a subsequent word is sent intact.
- Loopback: feed codeword into the corrector with each single bit 0..14 flipped in turn, for 50 random din values. Corrector output equals din every time.

Source files
------------

// File: rtl/hamming_tx_if.sv
// Handshake and serial-output bundle for the Hamming(15,11) transmit serializer.
// The producer side uses master, the serializer uses slave.
interface hamming_tx_if;
    logic [10:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [14:0] codeword;
    logic        serial_out;
    logic        serial_valid;
    logic        frame_start;
    logic        done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  codeword,
        input  serial_out,
        input  serial_valid,
        input  frame_start,
        input  done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output codeword,
        output serial_out,
        output serial_valid,
        output frame_start,
        output done
    );
endinterface

// File: rtl/hamming_tx_serializer.sv
// Hamming(15,11) encoder feeding an LSB-first serializer with a programmable bit period.
// Parity sits at codeword indices 0/1/3/7; every output is a flop driven from next-state logic.
module hamming_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    hamming_tx_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0] LAST_BIT = 4'd14;

    function automatic logic [14:0] hamming_encode(input logic [10:0] d);
        logic [14:0] c;
        c        = 15'd0;
        c[2]     = d[0];
        c[4]     = d[1];
        c[5]     = d[2];
        c[6]     = d[3];
        c[14:8]  = d[10:4];
        c[0]     = ^{c[2], c[4], c[6], c[8], c[10], c[12], c[14]};
        c[1]     = ^{c[2], c[5], c[6], c[9], c[10], c[13], c[14]};
        c[3]     = ^{c[4], c[5], c[6], c[11], c[12], c[13], c[14]};
        c[7]     = ^{c[8], c[9], c[10], c[11], c[12], c[13], c[14]};
        return c;
    endfunction

    state_e      state_q,        state_d;
    logic [14:0] shift_reg_q,    shift_reg_d;
    logic [14:0] codeword_q,     codeword_d;
    logic [3:0]  bit_idx_q,      bit_idx_d;
    logic [7:0]  cnt_q,          cnt_d;
    logic        din_ready_q,    din_ready_d;
    logic        serial_out_q,   serial_out_d;
    logic        serial_valid_q, serial_valid_d;
    logic        frame_start_q,  frame_start_d;
    logic        done_q,         done_d;
    logic [14:0] enc_s;

    assign enc_s = hamming_encode(bus.din);

    // Next-state and next-output decode; outputs describe the cycle after this edge.
    always_comb begin
        state_d        = state_q;
        shift_reg_d    = shift_reg_q;
        codeword_d     = codeword_q;
        bit_idx_d      = bit_idx_q;
        cnt_d          = cnt_q;
        din_ready_d    = 1'b0;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        frame_start_d  = 1'b0;
        done_d         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.din_valid) begin
                    state_d        = ST_SHIFT;
                    shift_reg_d    = enc_s;
                    codeword_d     = enc_s;
                    bit_idx_d      = 4'd0;
                    cnt_d          = 8'd0;
                    serial_out_d   = enc_s[0];
                    serial_valid_d = 1'b1;
                    frame_start_d  = 1'b1;
                end else begin
                    din_ready_d    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = 8'd0;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        bit_idx_d      = bit_idx_q + 4'd1;
                        serial_out_d   = shift_reg_q[bit_idx_q + 4'd1];
                        serial_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d          = cnt_q + 8'd1;
                    serial_out_d   = shift_reg_q[bit_idx_q];
                    serial_valid_d = 1'b1;
                    frame_start_d  = (bit_idx_q == 4'd0);
                end
            end
            ST_DONE: begin
                state_d     = ST_IDLE;
                bit_idx_d   = 4'd0;
                din_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                bit_idx_d   = 4'd0;
                cnt_d       = 8'd0;
                din_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            shift_reg_q    <= 15'd0;
            codeword_q     <= 15'd0;
            bit_idx_q      <= 4'd0;
            cnt_q          <= 8'd0;
            din_ready_q    <= 1'b1;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_reg_q    <= shift_reg_d;
            codeword_q     <= codeword_d;
            bit_idx_q      <= bit_idx_d;
            cnt_q          <= cnt_d;
            din_ready_q    <= din_ready_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            frame_start_q  <= frame_start_d;
            done_q         <= done_d;
        end
    end

    assign bus.din_ready    = din_ready_q;
    assign bus.codeword     = codeword_q;
    assign bus.serial_out   = serial_out_q;
    assign bus.serial_valid = serial_valid_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed bench for hamming_tx_serializer: one instance at one clock per bit, one at three.
// Expected codewords are hand-computed; loopback uses an independent syndrome corrector.
module tb_hamming_tx_serializer;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    hamming_tx_if bus1();
    hamming_tx_if bus3();

    hamming_tx_serializer #(.CLKS_PER_BIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    hamming_tx_serializer #(.CLKS_PER_BIT(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Syndrome decoder matching the downstream corrector's bit layout.
    function automatic logic [10:0] correct(input logic [14:0] c);
        logic [3:0]  s;
        logic [14:0] x;
        s = 4'd0;
        x = c;
        for (int i = 0; i < 15; i++) if (c[i]) s = s ^ 4'(i + 1);
        if (s != 4'd0) x[s - 4'd1] = ~x[s - 4'd1];
        return {x[14:8], x[6:4], x[2]};
    endfunction

    task automatic check_idle1(input string tag);
        check_eq({tag, "_ready"},  32'(bus1.din_ready),    32'd1);
        check_eq({tag, "_sval"},   32'(bus1.serial_valid), 32'd0);
        check_eq({tag, "_sout"},   32'(bus1.serial_out),   32'd0);
        check_eq({tag, "_fstart"}, 32'(bus1.frame_start),  32'd0);
        check_eq({tag, "_done"},   32'(bus1.done),         32'd0);
    endtask

    task automatic accept1(input logic [10:0] d, input bit hold);
        bus1.din       = d;
        bus1.din_valid = 1'b1;
        check_eq("accept_ready", 32'(bus1.din_ready), 32'd1);
        step();
        cyc = 1;
        if (!hold) bus1.din_valid = 1'b0;
    endtask

    // Entered in the first cycle after accept; leaves in the cycle where din_ready is back.
    task automatic run_frame1(input logic [14:0] exp_cw, input logic [10:0] next_din);
        for (int n = 0; n < 15; n++) begin
            check_eq($sformatf("sval_b%0d", n), 32'(bus1.serial_valid), 32'd1);
            check_eq($sformatf("sout_b%0d", n), 32'(bus1.serial_out),   32'(exp_cw[n]));
            check_eq($sformatf("fst_b%0d", n),  32'(bus1.frame_start),  32'(n == 0));
            check_eq($sformatf("cw_b%0d", n),   32'(bus1.codeword),     32'(exp_cw));
            check_eq($sformatf("rdy_b%0d", n),  32'(bus1.din_ready),    32'd0);
            if (n == 5)  bus1.din = 11'h2AA;
            if (n == 10) bus1.din = next_din;
            step();
        end
        check_eq("done_pulse", 32'(bus1.done),         32'd1);
        check_eq("done_sval",  32'(bus1.serial_valid), 32'd0);
        check_eq("done_sout",  32'(bus1.serial_out),   32'd0);
        check_eq("done_rdy",   32'(bus1.din_ready),    32'd0);
        step();
        check_eq("post_rdy",   32'(bus1.din_ready),    32'd1);
        check_eq("post_done",  32'(bus1.done),         32'd0);
        check_eq("post_cw",    32'(bus1.codeword),     32'(exp_cw));
        check_eq("spacing",    32'(cyc),               32'd17);
    endtask

    initial begin
        logic [10:0] rd;
        logic [14:0] cw;
        logic [14:0] flipped;
        logic [14:0] vec_cw  [4];
        logic [10:0] vec_din [4];
        bit exp_b;

        vec_din[0] = 11'h000; vec_cw[0] = 15'h0000;
        vec_din[1] = 11'h7FF; vec_cw[1] = 15'h7FFF;
        vec_din[2] = 11'h001; vec_cw[2] = 15'h0007;
        vec_din[3] = 11'h010; vec_cw[3] = 15'h0181;

        // Reset with din_valid asserted: must be ignored.
        rst_n          = 1'b0;
        bus1.din       = 11'h7FF;
        bus1.din_valid = 1'b1;
        bus3.din       = 11'h000;
        bus3.din_valid = 1'b0;
        repeat (3) step();
        check_idle1("rst");
        check_eq("rst_cw",    32'(bus1.codeword),  32'd0);
        check_eq("rst3_rdy",  32'(bus3.din_ready), 32'd1);
        check_eq("rst3_done", 32'(bus3.done),      32'd0);
        rst_n          = 1'b1;
        bus1.din_valid = 1'b0;
        step();
        check_idle1("rel");
        check_eq("rel_cw", 32'(bus1.codeword), 32'd0);

        // Encoding vectors at one clock per bit.
        for (int v = 0; v < 4; v++) begin
            accept1(vec_din[v], 1'b0);
            run_frame1(vec_cw[v], 11'h000);
        end

        // Back-to-back with din_valid held high: second accept exactly 17 cycles later.
        accept1(11'h001, 1'b1);
        run_frame1(15'h0007, 11'h7FF);
        step();
        cyc = 1;
        bus1.din_valid = 1'b0;
        run_frame1(15'h7FFF, 11'h000);

        // Mid-frame reset during bit 7.
        accept1(11'h001, 1'b0);
        repeat (7) step();
        check_eq("mid_b7_sval", 32'(bus1.serial_valid), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle1("midrst");
        for (int i = 0; i < 16; i++) begin
            step();
            check_eq("midrst_nodone", 32'(bus1.done),      32'd0);
            check_eq("midrst_rdy",    32'(bus1.din_ready), 32'd1);
        end
        accept1(11'h010, 1'b0);
        run_frame1(15'h0181, 11'h000);

        // Three clocks per bit, word 0x010 -> codeword bits 0, 7, 8.
        bus3.din       = 11'h010;
        bus3.din_valid = 1'b1;
        check_eq("c3_ready", 32'(bus3.din_ready), 32'd1);
        step();
        bus3.din_valid = 1'b0;
        for (int c = 1; c <= 47; c++) begin
            exp_b = (c >= 1 && c <= 3) || (c >= 22 && c <= 27);
            check_eq($sformatf("c3_sout_%0d", c), 32'(bus3.serial_out),   32'(exp_b));
            check_eq($sformatf("c3_sval_%0d", c), 32'(bus3.serial_valid), 32'(c <= 45));
            check_eq($sformatf("c3_fst_%0d", c),  32'(bus3.frame_start),  32'(c <= 3));
            check_eq($sformatf("c3_done_%0d", c), 32'(bus3.done),         32'(c == 46));
            check_eq($sformatf("c3_rdy_%0d", c),  32'(bus3.din_ready),    32'(c == 47));
            if (c < 47) step();
        end
        check_eq("c3_cw", 32'(bus3.codeword), 32'h0181);

        // Loopback: every single-bit error must be corrected back to din.
        for (int t = 0; t < 50; t++) begin
            rd = 11'($urandom_range(0, 2047));
            accept1(rd, 1'b0);
            cw = bus1.codeword;
            check_eq("lb_clean", 32'(correct(cw)), 32'(rd));
            for (int f = 0; f < 15; f++) begin
                flipped = cw ^ (15'd1 << f);
                check_eq($sformatf("lb_flip%0d", f), 32'(correct(flipped)), 32'(rd));
            end
            repeat (16) step();
            check_eq("lb_rdy", 32'(bus1.din_ready), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
